// File: rtl/uart_tx_sched_if.sv
// TileLink-style request/response channel used by uart_tx_sched to reach the UART
// register block: A carries address/data writes and reads, D returns read data.
interface tilelink;
    logic        a_valid;
    logic        a_ready;
    logic [3:0]  a_address;
    logic [31:0] a_data;
    logic        d_valid;
    logic        d_ready;
    logic [31:0] d_data;

    // Both channels: a beat transfers on a rising edge where valid && ready;
    // the source holds its payload stable while valid is high and ready is low.
    modport master (
        output a_valid, a_address, a_data, d_ready,
        input  a_ready, d_valid, d_data
    );

    modport slave (
        input  a_valid, a_address, a_data, d_ready,
        output a_ready, d_valid, d_data
    );
endinterface

// File: rtl/uart_tx_sched.sv
// Byte FIFO feeding a UART transmit register over a tilelink master port.
// Define UART_TX_SCHED_POLL_EN to poll the UART status register (Tx-Full) before each write.
module uart_tx_sched #(
    parameter int          DEPTH     = 8,
    parameter logic [31:0] INIT_CTRL = 32'h3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [7:0]               in_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     busy,
    tilelink.master                  bus,
    output logic [2:0]               dbg_state
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    localparam logic [3:0] ADDR_TX   = 4'h4;
    localparam logic [3:0] ADDR_STAT = 4'h8;
    localparam logic [3:0] ADDR_CTRL = 4'hc;

    typedef enum logic [2:0] {
        S_INIT   = 3'd0,
        S_IDLE   = 3'd1,
        S_STAT_A = 3'd2,
        S_STAT_D = 3'd3,
        S_TX_A   = 3'd4,
        S_GAP    = 3'd5
    } state_t;

    state_t             state_q, state_d;
    logic               init_go_q, init_go_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [7:0]         mem_q [DEPTH];
    logic [7:0]         mem_d [DEPTH];

    logic               push;
    logic               pop;
    logic               a_valid;
    logic [3:0]         a_address;
    logic [31:0]        a_data;
    logic               d_ready;

    // Only d_data[3] matters to the poll; the rest of the response is ignored.
    logic unused_bus;
    assign unused_bus = ^{bus.d_valid, bus.d_data};

    assign in_ready  = (count_q != CNT_FULL);
    assign push      = in_valid && in_ready;
    assign count     = count_q;
    assign busy      = (count_q != '0) || (state_q != S_IDLE);
    assign dbg_state = state_q;

    assign bus.a_valid   = a_valid;
    assign bus.a_address = a_address;
    assign bus.a_data    = a_data;
    assign bus.d_ready   = d_ready;

    always_comb begin
        state_d   = state_q;
        init_go_d = 1'b1;
        a_valid   = 1'b0;
        a_address = 4'h0;
        a_data    = 32'h0;
        d_ready   = 1'b0;
        pop       = 1'b0;
        case (state_q)
            S_INIT: begin
                // init_go_q keeps the control write off the bus until the first edge after reset.
                a_valid   = init_go_q;
                a_address = ADDR_CTRL;
                a_data    = INIT_CTRL;
                if (init_go_q && bus.a_ready) begin
                    state_d = S_GAP;
                end
            end
            S_IDLE: begin
                if (count_q != '0) begin
`ifdef UART_TX_SCHED_POLL_EN
                    state_d = S_STAT_A;
`else
                    state_d = S_TX_A;
`endif
                end
            end
`ifdef UART_TX_SCHED_POLL_EN
            S_STAT_A: begin
                a_valid   = 1'b1;
                a_address = ADDR_STAT;
                if (bus.a_ready) begin
                    state_d = S_STAT_D;
                end
            end
            S_STAT_D: begin
                d_ready = 1'b1;
                if (bus.d_valid) begin
                    state_d = bus.d_data[3] ? S_STAT_A : S_TX_A;
                end
            end
`endif
            S_TX_A: begin
                a_valid   = 1'b1;
                a_address = ADDR_TX;
                a_data    = {24'h0, mem_q[rd_ptr_q]};
                if (bus.a_ready) begin
                    pop     = 1'b1;
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_INIT;
            end
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        mem_d    = mem_q;
        if (push) begin
            mem_d[wr_ptr_q] = in_data;
            wr_ptr_d        = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_INIT;
            init_go_q <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            init_go_q <= init_go_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
        end
    end

    // Storage needs no reset: only entries between the pointers are ever read.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Self-checking bench for uart_tx_sched: a UART slave model on the tilelink port
// and a scoreboard of expected {address, data} bus writes in issue order.
module tb_uart_tx_sched;

    localparam int DEPTH = 8;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data  = 8'h0;
    logic       in_ready;
    logic [3:0] count;
    logic       busy;
    logic [2:0] dbg_state;

    tilelink tl ();

    uart_tx_sched #(
        .DEPTH     (DEPTH),
        .INIT_CTRL (32'h3)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .count     (count),
        .busy      (busy),
        .bus       (tl),
        .dbg_state (dbg_state)
    );

    int          vectors     = 0;
    int          miscompares = 0;
    logic [35:0] exp_q [$];
    logic [31:0] stat_q [$];
    int          ready_mode  = 0;   // 0: always ready, 1: stalled, 2: random
    logic        saw_dready  = 1'b0;
    logic        prev_pending = 1'b0;
    logic [35:0] prev_req    = '0;

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic expect_byte(input logic [7:0] b);
`ifdef UART_TX_SCHED_POLL_EN
        exp_q.push_back({4'h8, 32'h0});
`endif
        exp_q.push_back({4'h4, 24'h0, b});
    endtask

    // Called at posedge+1; returns whether the byte was taken at the next edge.
    task automatic push_raw(input logic [7:0] b, output logic acc);
        in_valid = 1'b1;
        in_data  = b;
        acc      = in_ready;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic push_byte(input logic [7:0] b, output logic acc);
        push_raw(b, acc);
        if (acc) expect_byte(b);
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 400; i++) begin
            if (!busy && exp_q.size() == 0) break;
            @(posedge clk);
            #1;
        end
        check({tag, "_busy"}, busy, 0);
        check({tag, "_pending"}, exp_q.size(), 0);
        check({tag, "_count"}, count, 0);
    endtask

    // Slave A-channel ready driver.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       tl.a_ready = 1'b1;
                1:       tl.a_ready = 1'b0;
                default: tl.a_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Slave D-channel: answer every status read with the next queued status word (0 when empty).
    initial begin
        forever begin
            @(negedge clk);
            saw_dready = saw_dready | tl.d_ready;
            if (tl.d_ready) begin
                tl.d_valid = 1'b1;
                tl.d_data  = (stat_q.size() != 0) ? stat_q.pop_front() : 32'h0;
            end else begin
                tl.d_valid = 1'b0;
                tl.d_data  = 32'h0;
            end
        end
    end

    // Bus monitor: scoreboard every accepted A beat and check payload hold during stalls.
    initial begin
        logic [35:0] req;
        forever begin
            @(negedge clk);
            req = {tl.a_address, tl.a_data};
            if (prev_pending && tl.a_valid) begin
                check("a_hold", req, prev_req);
            end
            if (tl.a_valid && tl.a_ready) begin
                check("a_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    check("a_beat", req, exp_q.pop_front());
                end
            end
            prev_pending = tl.a_valid && !tl.a_ready;
            prev_req     = req;
        end
    end

    initial begin
        logic acc;
        int   n_acc;
        tl.a_ready = 1'b1;
        tl.d_valid = 1'b0;
        tl.d_data  = 32'h0;

        // Reset values while rst_n is low.
        #1;
        check("rst_count", count, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_busy", busy, 1);
        check("rst_a_valid", tl.a_valid, 0);
        check("rst_d_ready", tl.d_ready, 0);
        exp_q.push_back({4'hc, 32'h3});
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("rel_a_valid", tl.a_valid, 0);
        wait_drain("init");

        // Two back-to-back bytes, drained in order.
        push_byte(8'h48, acc);
        check("hi_acc0", acc, 1);
        push_byte(8'h69, acc);
        check("hi_acc1", acc, 1);
        check("hi_count", count, 2);
        wait_drain("hi");

        // Fill with the bus stalled: ninth byte refused.
        ready_mode = 1;
        tl.a_ready = 1'b0;
        n_acc = 0;
        for (int i = 0; i < DEPTH + 1; i++) begin
            push_byte(8'($urandom_range(0, 255)), acc);
            if (acc) n_acc++;
        end
        check("full_accepted", n_acc, DEPTH);
        check("full_in_ready", in_ready, 0);
        check("full_count", count, DEPTH);
        ready_mode = 0;
        wait_drain("full");

        // Random gaps and random slave backpressure.
        ready_mode = 2;
        for (int i = 0; i < 12; i++) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
            acc = 1'b0;
            for (int t = 0; t < 50 && !acc; t++) begin
                push_byte(8'($urandom_range(0, 255)), acc);
            end
            check("rand_acc", acc, 1);
        end
        ready_mode = 0;
        wait_drain("rand");

`ifdef UART_TX_SCHED_POLL_EN
        // Tx-Full seen twice: three status reads before the single write.
        stat_q.push_back(32'h8);
        stat_q.push_back(32'h8);
        stat_q.push_back(32'h0);
        repeat (3) exp_q.push_back({4'h8, 32'h0});
        exp_q.push_back({4'h4, 32'h5a});
        push_raw(8'h5a, acc);
        check("poll_acc", acc, 1);
        wait_drain("poll");
        check("poll_stat_used", stat_q.size(), 0);
`endif

        // Reset while a TX write is pending with three bytes buffered.
`ifdef UART_TX_SCHED_POLL_EN
        ready_mode = 0;
`else
        ready_mode = 1;
        tl.a_ready = 1'b0;
`endif
        for (int i = 0; i < 3; i++) begin
            push_byte(8'hc0 + 8'(i), acc);
        end
        for (int i = 0; i < 50; i++) begin
            if (tl.a_valid && tl.a_address == 4'h4) begin
                ready_mode = 1;
                tl.a_ready = 1'b0;
                break;
            end
            @(posedge clk);
            #1;
        end
        check("mid_count", count, 3);
        check("mid_tx_addr", {tl.a_valid, tl.a_address}, {1'b1, 4'h4});
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_count", count, 0);
        check("mid_rst_a_valid", tl.a_valid, 0);
        check("mid_rst_in_ready", in_ready, 1);
        check("mid_rst_busy", busy, 1);
        exp_q.delete();
        exp_q.push_back({4'hc, 32'h3});
        ready_mode = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        wait_drain("post_rst");
        repeat (5) @(posedge clk);
        #1;
        check("post_rst_quiet", {busy, tl.a_valid}, 0);

`ifndef UART_TX_SCHED_POLL_EN
        check("no_poll_d_ready", saw_dready, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running want finished");
        $fatal(1);
    end

endmodule

// File: doc/uart_tx_sched.md
UART_TX_SCHED -- requirements
Module: uart_tx_sched

Interface
REQ-001 SHALL have parameter DEPTH, default 8, byte-FIFO entries (power of 2, >=2).
REQ-002 SHALL have parameter INIT_CTRL, default 32'h3, value written to UART control register after reset (reset Rx/Tx FIFOs).
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  1  requester byte valid.
REQ-006 SHALL have port in_ready  output  1  FIFO can accept byte.
REQ-007 SHALL have port in_data  input  8  byte to transmit.
REQ-008 SHALL have port count  output  $clog2(DEPTH)+1  bytes buffered.
REQ-009 SHALL have port busy  output  1  FIFO non-empty or FSM not in S_IDLE.
REQ-010 SHALL have port bus  tilelink.master  -  UART access: a_valid, a_ready, a_address, a_data, d_valid, d_ready, d_data.

Function
REQ-011 SHALL push in_data when in_valid && in_ready; in_ready = (count != DEPTH), and SHALL not depend on a same-cycle pop.
REQ-012 SHALL pop only stored entries (no bypass); a byte pushed in cycle N is first eligible to drive bus.a_data in cycle N+1.
REQ-013 SHALL, on simultaneous push and pop, leave count unchanged; pointers wrap modulo DEPTH.
REQ-014 SHALL implement FSM states S_INIT, S_IDLE, S_STAT_A, S_STAT_D, S_TX_A, S_GAP.
REQ-015 SHALL in S_INIT drive a_valid=1, a_address=4'hc, a_data=INIT_CTRL; on a_ready -> S_GAP.
REQ-016 SHALL in S_IDLE drive a_valid=0; if count!=0 -> S_STAT_A (poll enabled) or S_TX_A (poll disabled).
REQ-017 SHALL in S_STAT_A drive a_valid=1, a_address=4'h8; on a_ready -> S_STAT_D.
REQ-018 SHALL in S_STAT_D drive d_ready=1; on d_valid: d_data[3] (Tx-Full)=1 -> S_STAT_A, else -> S_TX_A.
REQ-019 SHALL in S_TX_A drive a_valid=1, a_address=4'h4, a_data={24'b0, fifo head}; on a_ready pop head -> S_GAP.
REQ-020 SHALL in S_GAP drive a_valid=0 for exactly one cycle -> S_IDLE (covers slave write-occupancy cycle).
REQ-021 SHALL hold a_address/a_data stable while a_valid=1 and a_ready=0.
REQ-022 SHALL drive d_ready=0 in all states except S_STAT_D.
REQ-023 SHALL transmit bytes strictly in push order, each exactly once.

Reset
REQ-024 SHALL on rst_n=0, asynchronously: state=S_INIT, pointers=0, count=0, in_ready=1, busy=1, a_valid=0 until first clock after release, d_ready=0.
REQ-025 SHALL discard all buffered bytes on reset mid-operation, including a write in S_TX_A not yet accepted.

Configuration
REQ-026 SHALL compile the status poll (S_STAT_A/S_STAT_D) only when macro UART_TX_SCHED_POLL_EN is defined.
REQ-027 SHALL, without UART_TX_SCHED_POLL_EN, go S_IDLE -> S_TX_A directly, never issue address 4'h8, and hold d_ready=0.

Verification
REQ-028 SHALL cover: reset release -> one write addr 4'hc data 32'h3, then S_IDLE, busy=0 with empty FIFO.
REQ-029 SHALL cover: push 0x48,0x69 back-to-back, slave status 0 -> TX writes 0x48 then 0x69 in order, count 2->0.
REQ-030 SHALL cover: DEPTH=8, push 9 bytes with bus stalled (a_ready=0) -> in_ready=0 at count=8, 9th byte not accepted.
REQ-031 SHALL cover (POLL_EN): status d_data=32'h8 twice then 32'h0 -> three status reads, then one TX write.
REQ-032 SHALL cover: rst_n low during S_TX_A with count=3 -> count=0, a_valid=0 asynchronously, only init write follows.
